// File: rtl/bit_timer_ctrl.sv
// Serial frame timing sequencer: clocks-per-bit and bit-index counters with
// mid-bit shift strobe, frame-done pulse and start-time configuration check.
module bit_timer_ctrl #(
    parameter int unsigned CLK_CNT_BITS = 4,
    parameter int unsigned BIT_CNT_BITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [CLK_CNT_BITS-1:0] i_clks_per_bit,
    input  logic [CLK_CNT_BITS-1:0] i_sample_phase,
    input  logic [BIT_CNT_BITS-1:0] i_num_bits,
    output logic                    o_busy,
    output logic                    o_shift_strobe,
    output logic [BIT_CNT_BITS-1:0] o_bit_index,
    output logic                    o_frame_done,
    output logic                    o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CLK_CNT_BITS-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [BIT_CNT_BITS-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [CLK_CNT_BITS-1:0] r_cpb, w_cpb_nxt;
    logic [CLK_CNT_BITS-1:0] r_sp, w_sp_nxt;
    logic [BIT_CNT_BITS-1:0] r_nb, w_nb_nxt;
    logic                    r_cfg_err, w_cfg_err_nxt;
    logic                    w_cfg_legal;

    assign w_cfg_legal = (i_clks_per_bit >= CLK_CNT_BITS'(2)) &&
                         (i_num_bits != '0) &&
                         (i_sample_phase != '0) &&
                         (i_sample_phase <= i_clks_per_bit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_cpb     <= '0;
            r_sp      <= '0;
            r_nb      <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cpb     <= w_cpb_nxt;
            r_sp      <= w_sp_nxt;
            r_nb      <= w_nb_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    // Abort wins over start, rollover and DONE; wrap to 1 keeps bits cpb cycles long.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cpb_nxt     = r_cpb;
        w_sp_nxt      = r_sp;
        w_nb_nxt      = r_nb;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    if (w_cfg_legal) begin
                        w_cpb_nxt     = i_clks_per_bit;
                        w_sp_nxt      = i_sample_phase;
                        w_nb_nxt      = i_num_bits;
                        w_clk_cnt_nxt = CLK_CNT_BITS'(1);
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt   = S_IDLE;
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                end else if (r_clk_cnt == r_cpb) begin
                    w_clk_cnt_nxt = CLK_CNT_BITS'(1);
                    if (r_bit_cnt == r_nb - BIT_CNT_BITS'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_BITS'(1);
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CLK_CNT_BITS'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_busy         = (r_state != S_IDLE);
        o_shift_strobe = (r_state == S_RUN) && (r_clk_cnt == r_sp);
        o_bit_index    = (r_state == S_RUN) ? r_bit_cnt : '0;
        o_frame_done   = (r_state == S_DONE);
        o_cfg_err      = r_cfg_err;
    end

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Self-checking bench for bit_timer_ctrl: elapsed-time frame model compared every
// cycle, plus literal strobe/done/error timelines for each directed scenario.
module tb_bit_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cpb = 4'd0;
    logic [3:0] sp = 4'd0;
    logic [3:0] nb = 4'd0;
    logic       busy, strobe, done, cfg_err;
    logic [3:0] idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int strobe_q[$];
    int idx_q[$];
    int done_q[$];
    int err_q[$];

    // Frame model: elapsed cycle count since acceptance decides every output.
    bit m_active = 1'b0;
    bit m_err = 1'b0;
    int m_t = 0;
    int m_cpb = 0, m_sp = 0, m_nb = 0;

    bit_timer_ctrl #(.CLK_CNT_BITS(4), .BIT_CNT_BITS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_clks_per_bit(cpb), .i_sample_phase(sp), .i_num_bits(nb),
        .o_busy(busy), .o_shift_strobe(strobe), .o_bit_index(idx),
        .o_frame_done(done), .o_cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_%0d", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_err    = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_active) begin
                if (abort || m_t == m_cpb * m_nb + 1) begin
                    m_active = 1'b0;
                    m_t      = 0;
                end else begin
                    m_t++;
                end
            end else if (start && !abort) begin
                if (cpb >= 2 && nb != 0 && sp != 0 && sp <= cpb) begin
                    m_cpb = int'(cpb); m_sp = int'(sp); m_nb = int'(nb);
                    m_active = 1'b1;
                    m_t      = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        int total;
        bit in_run;
        cyc++;
        #1;
        total  = m_cpb * m_nb;
        in_run = m_active && (m_t <= total);
        chk("busy", int'(busy), int'(m_active));
        chk("shift_strobe", int'(strobe),
            int'(in_run && (((m_t - 1) % m_cpb) + 1 == m_sp)));
        chk("bit_index", int'(idx), in_run ? (m_t - 1) / m_cpb : 0);
        chk("frame_done", int'(done), int'(m_active && m_t == total + 1));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        if (strobe) begin
            strobe_q.push_back(cyc - base);
            idx_q.push_back(int'(idx));
        end
        if (done) done_q.push_back(cyc - base);
        if (cfg_err) err_q.push_back(cyc - base);
    end

    task automatic begin_frame(input int c, input int s, input int n);
        @(negedge clk);
        cpb = 4'(c); sp = 4'(s); nb = 4'(n);
        start = 1'b1;
        base = cyc;
        strobe_q.delete(); idx_q.delete(); done_q.delete(); err_q.delete();
    endtask

    task automatic wait_rel(input int rel);
        int n = 0;
        while (cyc - base < rel && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic nominal(input string name);
        begin_frame(4, 2, 3);
        @(negedge clk) start = 1'b0;
        cpb = 4'd9; sp = 4'd1; nb = 4'd1;
        wait_idle(name, 40);
        chk_list({name, "_strobe"}, strobe_q, '{2, 6, 10});
        chk_list({name, "_idx"}, idx_q, '{0, 1, 2});
        chk_list({name, "_done"}, done_q, '{13});
    endtask

    initial begin
        int exp_s[$];
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idx", int'(idx), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        nominal("s1");

        begin_frame(15, 15, 15);
        @(negedge clk) start = 1'b0;
        wait_idle("s2", 260);
        for (int k = 1; k <= 15; k++) exp_s.push_back(15 * k);
        chk_list("s2_strobe", strobe_q, exp_s);
        chk_list("s2_done", done_q, '{226});

        begin_frame(4, 2, 0);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk_list("s3a_err", err_q, '{1});
        begin_frame(1, 1, 3);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk_list("s3b_err", err_q, '{1});
        begin_frame(4, 5, 3);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk_list("s3c_err", err_q, '{1});
        chk("s3c_strobes", strobe_q.size(), 0);

        begin_frame(4, 2, 3);
        @(negedge clk) start = 1'b0;
        wait_rel(5);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("s4_busy_c6", int'(busy), 0);
        wait_idle("s4", 40);
        chk_list("s4_strobe", strobe_q, '{2});
        chk("s4_done", done_q.size(), 0);
        nominal("s4_after");

        begin_frame(4, 2, 3);
        wait_rel(15);
        start = 1'b0;
        wait_idle("s5", 40);
        chk_list("s5_done", done_q, '{13, 27});
        chk_list("s5_strobe", strobe_q, '{2, 6, 10, 16, 20, 24});

        begin_frame(4, 2, 3);
        @(negedge clk) start = 1'b0;
        wait_rel(7);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_busy", int'(busy), 0);
        chk("s6_async_idx", int'(idx), 0);
        chk("s6_async_strobe", int'(strobe), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("s6_done", done_q.size(), 0);
        nominal("s6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_timer_ctrl.md
Name: bit_timer_ctrl

Overview:
Sequencer that drives a two-level flex-counter datapath for serial frame timing: a clock-per-bit counter and a bit-index counter. It accepts a start request and latches the timing configuration. It emits a one-cycle mid-bit sample strobe for each bit and a frame-done pulse, then returns to idle. It sits between the serial receive/transmit control logic and its shift register, replacing ad hoc enable/clear wiring of separate counters.

Parameters:
CLK_CNT_BITS, 4, width of the clocks-per-bit counter and the clks_per_bit / sample_phase inputs
BIT_CNT_BITS, 4, width of the bit counter and the num_bits / bit_index signals

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new frame; sampled only in IDLE
abort  input  1  terminate the current frame immediately
clks_per_bit  input  CLK_CNT_BITS  clock cycles per bit; legal range 2..2^CLK_CNT_BITS-1
sample_phase  input  CLK_CNT_BITS  clock count within a bit at which to strobe; legal range 1..clks_per_bit
num_bits  input  BIT_CNT_BITS  bits per frame; legal range 1..2^BIT_CNT_BITS-1
busy  output  1  high while a frame is in progress (state != IDLE)
shift_strobe  output  1  one-cycle pulse at the sample point of each bit
bit_index  output  BIT_CNT_BITS  index of the current bit, 0..num_bits-1
frame_done  output  1  one-cycle pulse after the last bit completes
cfg_err  output  1  one-cycle pulse when start is rejected for illegal configuration

Behaviour:
- Reset (async, rst=1): state=IDLE; clk_cnt=0, bit_cnt=0; latched config = 0; all outputs 0.
- Clock and reset are fixed as above: one clock (clk); reset rst is asynchronous and active-high.
- FSM states: IDLE, RUN, DONE. Outputs are Moore decodes of registered state, except cfg_err, which is a registered pulse.
- IDLE, start=1, abort=0, config legal:
  - Latch clks_per_bit, sample_phase and num_bits into internal registers.
  - Next state RUN with clk_cnt=1, bit_cnt=0.
  - Config inputs are don't-care after acceptance.
- IDLE, start=1, config illegal (clks_per_bit<2, num_bits==0, sample_phase==0, or sample_phase>clks_per_bit):
  - Stay in IDLE.
  - cfg_err=1 for exactly the next cycle.
- RUN, on each edge, unless abort:
  - clk_cnt==clks_per_bit_q: clk_cnt<=1.
    - If bit_cnt==num_bits_q-1, state<=DONE.
    - Otherwise bit_cnt<=bit_cnt+1.
  - Otherwise clk_cnt<=clk_cnt+1.
  - Wrap is to 1, not 0, so each bit occupies exactly clks_per_bit cycles. No counter ever exceeds its latched limit.
- DONE: frame_done=1 for one cycle; next state IDLE; clk_cnt and bit_cnt cleared to 0.
- Output decodes:
  - shift_strobe = (state==RUN) && (clk_cnt==sample_phase_q).
  - bit_index = bit_cnt in RUN, 0 otherwise.
  - busy = (state != IDLE).
- Frame timing: start sampled at edge E gives RUN for clks_per_bit_q*num_bits_q cycles, then one DONE cycle, then IDLE.
- abort:
  - In RUN or DONE: next state IDLE, counters cleared, no frame_done and no further strobe.
  - Overrides rollover and DONE.
  - In IDLE: abort has priority over start; start is ignored and cfg_err is not raised.
- start while busy (RUN or DONE) is ignored; no queuing. A new frame requires start high in a cycle where state==IDLE.
- Config input changes during RUN have no effect.
- Reset asserted mid-frame: immediate return to reset values; no frame_done.

Test Plan:
1. Nominal frame, clks_per_bit=4, sample_phase=2, num_bits=3, start high in cycle 0 -> busy high in cycles 1-13; shift_strobe in cycles 2, 6, 10 with bit_index 0, 1, 2; frame_done only in cycle 13; busy low from cycle 14.
2. Max values, clks_per_bit=15, sample_phase=15, num_bits=15 -> 225 RUN cycles; strobe in the last cycle of each bit (cycles 15, 30, ..., 225); frame_done in cycle 226; no counter wraps past 15.
3. Illegal configs, start with num_bits=0, then clks_per_bit=1, then sample_phase=5 with clks_per_bit=4 -> cfg_err pulses exactly one cycle each time; busy stays 0; no strobes.
4. Abort at cycle 5 of the nominal frame -> IDLE in cycle 6; busy=0; no frame_done; no strobe after cycle 2. A following start then runs a full frame identical to scenario 1.
5. start held high continuously with the nominal config -> frames back-to-back; frame_done in cycle 13; next frame accepted in IDLE cycle 14; second frame_done in cycle 27; start ignored in cycles 1-13.
6. Async rst pulsed mid-cycle during bit 1 -> all outputs 0 immediately without a clock edge; frame_done never asserts; a clean start after deassertion behaves as in scenario 1.
